// File: rtl/gain_ramp_ctrl.sv
// AXI4-Lite write-only master that ramps each channel's gain toward its target
// by at most STEP per audio frame tick, writing every new value to the pregain slave.
module gain_ramp_ctrl #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h0000_0000,
  parameter int                            NUM_CH             = 4,
  parameter logic [15:0]                   STEP               = 16'h0100
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            sample_tick,
  input  logic                            tgt_we,
  input  logic [1:0]                      tgt_ch,
  input  logic [15:0]                     tgt_gain,
  input  logic                            err_clr,
  output logic                            busy,
  output logic                            err,
  output logic                            overrun,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;

  state_t                          state_q, state_d;
  logic [15:0]                     tgt_q [NUM_CH];
  logic [15:0]                     cur_q [NUM_CH];
  logic [1:0]                      ch_q;
  logic [15:0]                     nxt_q, nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic                            aw_done_q, w_done_q;
  logic                            pending_q, err_q, overrun_q;
  logic [15:0]                     cur_sel, tgt_sel;
  logic                            mismatch, last_ch, aw_hs, w_hs, b_hs;

  assign cur_sel  = cur_q[ch_q];
  assign tgt_sel  = tgt_q[ch_q];
  assign mismatch = (cur_sel != tgt_sel);
  assign last_ch  = (ch_q == 2'(NUM_CH - 1));
  assign aw_hs    = (state_q == WRITE) && !aw_done_q && M_AXI_AWREADY;
  assign w_hs     = (state_q == WRITE) && !w_done_q && M_AXI_WREADY;
  assign b_hs     = (state_q == RESP) && M_AXI_BVALID;

  // Saturating step toward target; differences are taken in the direction that cannot underflow.
  always_comb begin
    nxt = cur_sel;
    if (tgt_sel > cur_sel)
      nxt = ((tgt_sel - cur_sel) > STEP) ? cur_sel + STEP : tgt_sel;
    else if (tgt_sel < cur_sel)
      nxt = ((cur_sel - tgt_sel) > STEP) ? cur_sel - STEP : tgt_sel;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pending_q) state_d = SCAN;
      SCAN:  if (mismatch) state_d = WRITE;
             else if (last_ch) state_d = IDLE;
      WRITE: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = RESP;
      RESP:  if (M_AXI_BVALID) state_d = last_ch ? IDLE : SCAN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    M_AXI_AWVALID = (state_q == WRITE) && !aw_done_q;
    M_AXI_WVALID  = (state_q == WRITE) && !w_done_q;
    M_AXI_BREADY  = (state_q == RESP);
    M_AXI_AWADDR  = addr_q;
    M_AXI_AWPROT  = '0;
    M_AXI_WDATA   = {{(C_M_AXI_DATA_WIDTH-16){1'b0}}, nxt_q};
    M_AXI_WSTRB   = '1;
    err           = err_q;
    overrun       = overrun_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
      end
      ch_q      <= '0;
      nxt_q     <= '0;
      addr_q    <= BASE_ADDR;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (tgt_we && (int'(tgt_ch) < NUM_CH))
        tgt_q[tgt_ch] <= tgt_gain;

      // A tick landing on the cycle the scan starts re-arms pending for the following scan.
      pending_q <= sample_tick || (pending_q && (state_q != IDLE));

      if (sample_tick && pending_q) overrun_q <= 1'b1;
      else if (err_clr)             overrun_q <= 1'b0;

      if (b_hs && (M_AXI_BRESP != 2'b00)) err_q <= 1'b1;
      else if (err_clr)                   err_q <= 1'b0;

      unique case (state_q)
        IDLE: if (pending_q) ch_q <= '0;
        SCAN: begin
          if (mismatch) begin
            nxt_q     <= nxt;
            addr_q    <= BASE_ADDR + C_M_AXI_ADDR_WIDTH'({ch_q, 2'b00});
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else if (!last_ch) begin
            ch_q <= ch_q + 2'd1;
          end
        end
        WRITE: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        RESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP == 2'b00) cur_q[ch_q] <= nxt_q;
            if (!last_ch) ch_q <= ch_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Scoreboard bench for gain_ramp_ctrl: stimulus pushes expected writes, a monitor pops
// and compares on every B handshake; a small AXI-Lite slave model supplies backpressure.
module tb_gain_ramp_ctrl;

  logic        tb_ACLK;
  logic        ARESETN;
  logic        sample_tick, tgt_we, err_clr;
  logic [1:0]  tgt_ch;
  logic [15:0] tgt_gain;
  logic        busy, err, overrun;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   b_count  = 0;
  int   aw_delay = 0;
  int   w_delay  = 0;
  int   b_delay  = 0;
  logic [1:0] bresp_cfg = 2'b00;

  gain_ramp_ctrl #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .BASE_ADDR(32'h0000_0000),
    .NUM_CH(4),
    .STEP(16'h0100)
  ) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN),
    .sample_tick(sample_tick), .tgt_we(tgt_we), .tgt_ch(tgt_ch), .tgt_gain(tgt_gain),
    .err_clr(err_clr), .busy(busy), .err(err), .overrun(overrun),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  initial begin
    tb_ACLK = 1'b0;
    forever #5 tb_ACLK = ~tb_ACLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge tb_ACLK); #1;
    sample_tick = 1'b1;
    @(posedge tb_ACLK); #1;
    sample_tick = 1'b0;
  endtask

  task automatic set_tgt(input logic [1:0] ch, input logic [15:0] g);
    @(posedge tb_ACLK); #1;
    tgt_we = 1'b1; tgt_ch = ch; tgt_gain = g;
    @(posedge tb_ACLK); #1;
    tgt_we = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(posedge tb_ACLK); #1;
    err_clr = 1'b1;
    @(posedge tb_ACLK); #1;
    err_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge tb_ACLK); #1;
    while (busy && n < 500) begin
      @(posedge tb_ACLK); #1;
      n++;
    end
    if (busy) begin
      n_checks++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  // Slave model: per-channel ready delays, programmable B delay and response.
  initial begin
    bit got_aw, got_w, hs_aw, hs_w, hs_b;
    int aw_cnt, w_cnt, guard;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    M_AXI_BVALID  = 1'b0; M_AXI_BRESP  = 2'b00;
    forever begin
      @(posedge tb_ACLK); #1;
      if (ARESETN && (M_AXI_AWVALID || M_AXI_WVALID)) begin
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; guard = 0;
        while (!(got_aw && got_w) && guard < 100) begin
          M_AXI_AWREADY = !got_aw && (aw_cnt >= aw_delay);
          M_AXI_WREADY  = !got_w && (w_cnt >= w_delay);
          @(negedge tb_ACLK);
          hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
          hs_w  = M_AXI_WVALID && M_AXI_WREADY;
          @(posedge tb_ACLK); #1;
          if (hs_aw) got_aw = 1;
          if (hs_w)  got_w  = 1;
          aw_cnt++; w_cnt++; guard++;
        end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        repeat (b_delay) begin
          @(posedge tb_ACLK); #1;
        end
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp_cfg;
        hs_b = 0; guard = 0;
        while (!hs_b && guard < 100) begin
          @(negedge tb_ACLK);
          hs_b = M_AXI_BREADY;
          @(posedge tb_ACLK); #1;
          guard++;
        end
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
      end
    end
  end

  // Monitor: handshake stability and scoreboard comparison on each accepted B.
  initial begin
    bit          prev_aw, prev_w;
    logic [31:0] prev_addr, prev_data, cap_addr, cap_data;
    exp_t        e;
    prev_aw = 0; prev_w = 0; prev_addr = '0; prev_data = '0; cap_addr = '0; cap_data = '0;
    forever begin
      @(negedge tb_ACLK);
      if (!ARESETN) begin
        prev_aw = 0; prev_w = 0;
      end else begin
        if (prev_aw) begin
          chk("awvalid_held", 32'(M_AXI_AWVALID), 32'd1);
          chk("awaddr_stable", M_AXI_AWADDR, prev_addr);
        end
        if (prev_w) begin
          chk("wvalid_held", 32'(M_AXI_WVALID), 32'd1);
          chk("wdata_stable", M_AXI_WDATA, prev_data);
        end
        prev_aw   = M_AXI_AWVALID && !M_AXI_AWREADY;
        prev_w    = M_AXI_WVALID && !M_AXI_WREADY;
        prev_addr = M_AXI_AWADDR;
        prev_data = M_AXI_WDATA;
        if (M_AXI_AWVALID && M_AXI_AWREADY) cap_addr = M_AXI_AWADDR;
        if (M_AXI_WVALID && M_AXI_WREADY)   cap_data = M_AXI_WDATA;
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          b_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected", cap_addr, cap_data);
          end else begin
            e = exp_q.pop_front();
            chk("b_addr", cap_addr, e.addr);
            chk("b_data", cap_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    int busy_cycles, base, seen;
    ARESETN = 1'b0; sample_tick = 1'b0; tgt_we = 1'b0; tgt_ch = '0; tgt_gain = '0; err_clr = 1'b0;

    // Reset held for 10 cycles with a tick pulsed inside it
    repeat (4) @(posedge tb_ACLK);
    #1 sample_tick = 1'b1;
    @(posedge tb_ACLK); #1 sample_tick = 1'b0;
    repeat (4) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
    chk("rst_wvalid",  32'(M_AXI_WVALID),  32'd0);
    chk("rst_bready",  32'(M_AXI_BREADY),  32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_err",     32'(err),           32'd0);
    chk("rst_overrun", 32'(overrun),       32'd0);
    chk("rst_awaddr",  M_AXI_AWADDR,       32'h0000_0000);
    chk("rst_wdata",   M_AXI_WDATA,        32'h0000_0000);
    @(posedge tb_ACLK); #1 ARESETN = 1'b1;
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // All-zero targets: scan of 4 channels, no writes
    tick();
    busy_cycles = 0;
    repeat (20) begin
      @(negedge tb_ACLK);
      if (busy) busy_cycles++;
    end
    chk("zero_scan_busy_cycles", 32'(busy_cycles), 32'd4);
    chk("zero_scan_writes", 32'(b_count), 32'd0);

    // Ramp up ch0 to 0x300
    set_tgt(2'd0, 16'h0300);
    push(32'h0, 32'h100); tick(); wait_idle();
    push(32'h0, 32'h200); tick(); wait_idle();
    push(32'h0, 32'h300); tick(); wait_idle();
    base = b_count;
    tick(); wait_idle();
    chk("ramp_settled_no_write", 32'(b_count - base), 32'd0);

    // ch1 up to 0x300, then clamp down with ch3 alongside
    set_tgt(2'd1, 16'h0300);
    push(32'h4, 32'h100); tick(); wait_idle();
    push(32'h4, 32'h200); tick(); wait_idle();
    push(32'h4, 32'h300); tick(); wait_idle();
    set_tgt(2'd1, 16'h0050);
    set_tgt(2'd3, 16'h0080);
    push(32'h4, 32'h200); push(32'hC, 32'h080); tick(); wait_idle();
    push(32'h4, 32'h100); tick(); wait_idle();
    push(32'h4, 32'h050); tick(); wait_idle();
    chk("multi_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on ch2: AWREADY late, WREADY immediate, B delayed
    aw_delay = 5; w_delay = 0; b_delay = 3;
    base = b_count;
    set_tgt(2'd2, 16'h0040);
    push(32'h8, 32'h040);
    tick();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge tb_ACLK);
      if (M_AXI_AWVALID) seen = 1;
    end
    chk("bp_awvalid_seen", 32'(seen), 32'd1);
    chk("bp_wvalid_first", 32'(M_AXI_WVALID), 32'd1);
    @(negedge tb_ACLK);
    chk("bp_wvalid_dropped", 32'(M_AXI_WVALID), 32'd0);
    chk("bp_awvalid_waiting", 32'(M_AXI_AWVALID), 32'd1);
    wait_idle();
    repeat (5) @(posedge tb_ACLK);
    chk("bp_one_b", 32'(b_count - base), 32'd1);
    aw_delay = 0; b_delay = 0;

    // Error path: ch0 ramps down, the 0x100 write is rejected once then retried
    set_tgt(2'd0, 16'h0000);
    push(32'h0, 32'h200); tick(); wait_idle();
    chk("err_before", 32'(err), 32'd0);
    bresp_cfg = 2'b10;
    push(32'h0, 32'h100); tick(); wait_idle();
    @(negedge tb_ACLK);
    chk("err_set", 32'(err), 32'd1);
    bresp_cfg = 2'b00;
    push(32'h0, 32'h100); tick(); wait_idle();
    @(negedge tb_ACLK);
    chk("err_sticky", 32'(err), 32'd1);
    pulse_err_clr();
    @(negedge tb_ACLK);
    chk("err_cleared", 32'(err), 32'd0);
    push(32'h0, 32'h000); tick(); wait_idle();

    // Overrun: two ticks during a slow ch3 write merge into one extra scan
    aw_delay = 5;
    base = b_count;
    set_tgt(2'd3, 16'h0380);
    push(32'hC, 32'h180); push(32'hC, 32'h280);
    tick();
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge tb_ACLK);
      if (M_AXI_AWVALID) seen = 1;
    end
    chk("ovr_awvalid_seen", 32'(seen), 32'd1);
    chk("ovr_before", 32'(overrun), 32'd0);
    tick();
    tick();
    @(negedge tb_ACLK);
    chk("ovr_set", 32'(overrun), 32'd1);
    repeat (100) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("ovr_two_writes", 32'(b_count - base), 32'd2);
    chk("ovr_idle", 32'(busy), 32'd0);
    pulse_err_clr();
    @(negedge tb_ACLK);
    chk("ovr_cleared", 32'(overrun), 32'd0);
    aw_delay = 0;

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gain_ramp_ctrl.md
# gain_ramp_ctrl

AXI4-Lite master sequencer that owns the gain registers of the Volume_Pregain slave and ramps each channel's gain toward a software- or mixer-supplied target. On each audio frame tick it steps every mismatched channel by at most STEP and writes the new value to the slave. This prevents zipper noise from abrupt gain changes. It sits between the mixer control logic and the S00_AXI port of the pregain IP and is the only master on that port.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
- BASE_ADDR, 32'h0000_0000, slave base; channel n register at BASE_ADDR + 4*n
- NUM_CH, 4, number of gain channels/registers (2..4)
- STEP, 16'h0100, maximum gain change per tick (unsigned, nonzero)

Ports:
- ACLK  in  1  clock; all logic rising-edge
- ARESETN  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle pulse per audio frame
- tgt_we  in  1  target write strobe
- tgt_ch  in  2  channel index for tgt_we (ignored if >= NUM_CH)
- tgt_gain  in  16  new target gain, unsigned Q8.8
- err_clr  in  1  clears err and overrun
- busy  out  1  high whenever FSM not in IDLE
- err  out  1  sticky; set on any BRESP != OKAY
- overrun  out  1  sticky; set when a tick arrives while a tick is already pending
- M_AXI_AWADDR  out  32, M_AXI_AWPROT  out  3 (constant 0), M_AXI_AWVALID  out  1, M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32, M_AXI_WSTRB  out  4 (constant 4'hF), M_AXI_WVALID  out  1, M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2, M_AXI_BVALID  in  1, M_AXI_BREADY  out  1
- Read channels are not implemented. The block is write-only.

## Operation
- Per channel state: tgt[n] and cur[n] (16 bits each). Both reset to 0, which matches the slave's reset contents.
- tgt_we writes tgt[tgt_ch] at the clock edge. It is accepted in any state and never stalls.
- sample_tick sets pending. A tick that arrives while pending is already 1 sets overrun; ticks merge and are never queued.
- FSM states: IDLE, SCAN, WRITE, RESP.
- IDLE -> SCAN when pending = 1. On that transition: clear pending, set ch = 0.
- SCAN, one cycle per channel:
  - If cur[ch] != tgt[ch]: compute nxt and go to WRITE.
  - Otherwise, if ch = NUM_CH-1, go to IDLE; else increment ch.
- nxt arithmetic (unsigned 16-bit, never wraps):
  - If tgt > cur: nxt = (tgt - cur > STEP) ? cur + STEP : tgt.
  - If tgt < cur: nxt = (cur - tgt > STEP) ? cur - STEP : tgt.
- WRITE:
  - AWADDR = BASE_ADDR + 4*ch; WDATA = {16'h0, nxt}.
  - AWVALID and WVALID are asserted together. Each drops independently after its own handshake.
  - Go to RESP once both handshakes have completed. They may complete in either order or in the same cycle.
- RESP: BREADY = 1. On BVALID:
  - If BRESP = OKAY: cur[ch] <= nxt.
  - Otherwise: set err and leave cur[ch] unchanged, so the next tick retries.
  - Then go to IDLE if ch = NUM_CH-1; else increment ch and return to SCAN.
- Channels are serviced in ascending index order, with at most one write per channel per tick.
- tgt changing during WRITE/RESP does not alter the in-flight nxt. The new target takes effect from the next scan.
- err_clr clears err and overrun. If err_clr and a setting event occur in the same cycle, the set wins.

## Timing
- Reset values:
  - AWVALID, WVALID, BREADY, busy, err, overrun, pending = 0.
  - AWADDR = BASE_ADDR, WDATA = 0.
  - FSM in IDLE; all cur and tgt = 0.
- Asynchronous reset mid-transaction aborts immediately and drops all valids. The slave must be reset by the same ARESETN.
- Tick at edge k: pending = 1 after k; SCAN begins at k+1; first AWVALID/WVALID visible after k+2 if ch0 mismatches.
- Handshake rules while VALID is high:
  - AWADDR and WDATA are held stable.
  - VALID is never withdrawn before its READY.
  - VALID does not depend combinationally on READY.
- BREADY is asserted only in RESP.
- Best case with an always-ready slave and BVALID one cycle after the W handshake: 3 cycles per channel write (SCAN, WRITE, RESP).

## Test plan
- Reset: hold ARESETN low for 10 cycles and pulse sample_tick -> all outputs at reset values, no AWVALID; after release, a tick with all tgt = 0 produces no writes and busy returns low within NUM_CH+1 cycles.
- Ramp up: tgt_we ch0 = 16'h0300, three ticks -> writes to 0x0 with WDATA 0x100, 0x200, 0x300; a fourth tick produces no write.
- Clamp down plus multi-channel: ch1 at 0x0300, then tgt ch1 = 0x0050 and tgt ch3 = 0x0080 -> each tick writes 0x4 before 0xC; ch1 values 0x200, 0x100, 0x050; ch3 value 0x080 on the first tick only.
- Backpressure: AWREADY held low 5 cycles, WREADY immediate, BVALID delayed 3 cycles -> WVALID drops after 1 cycle; AWADDR stable until its handshake; exactly one B accepted; no second write.
- Error path: slave returns SLVERR (2'b10) for ch0 value 0x100 -> err = 1 and cur unchanged; next tick rewrites 0x100 to 0x0; err_clr clears err.
- Overrun: two ticks issued while busy -> overrun = 1, and only one additional scan runs after the current one.
